// File: rtl/dxl_pkg.sv
// rtl/dxl_pkg.sv - shared codes and state type for the Dynamixel command scheduler
package dxl_pkg;

    localparam logic [2:0] RW_W0   = 3'b101;
    localparam logic [2:0] RW_W1   = 3'b110;
    localparam logic [2:0] RW_CTRL = 3'b100;
    localparam logic [2:0] RW_NONE = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        LD0,
        LD1,
        START,
        CLEAR,
        WAIT_HI,
        WAIT_LO,
        GAP
    } sched_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dxl_rr_arbiter.sv
// rtl/dxl_rr_arbiter.sv - round-robin winner select with last-grant pointer
module dxl_rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             grant,
    output logic [PW-1:0]    winner,
    output logic             valid
);

    logic [PW-1:0] last_q;
    int            idx;

    // Scan from the farthest offset down so the nearest pending source after last_q wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int off = N_REQ; off >= 1; off--) begin
            idx = (int'(last_q) + off) % N_REQ;
            if (req[idx]) begin
                winner = PW'(idx);
                valid  = 1'b1;
            end
        end
    end

    // Pointer starts at the last source so source 0 is first after reset; moves only on grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PW'(N_REQ - 1);
        end else if (grant) begin
            last_q <= winner;
        end
    end

endmodule

// File: rtl/dxl_cmd_scheduler.sv
// rtl/dxl_cmd_scheduler.sv - shares one UART_Dynamixel between several command sources
module dxl_cmd_scheduler
    import dxl_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int GAP_CYCLES = 500,
    parameter int START_TO   = 1_000,
    parameter int TX_TO      = 2_500_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   cmd_w0,
    input  logic [32*N_REQ-1:0]   cmd_w1,
    output logic [N_REQ-1:0]      ack,
    output logic [N_REQ-1:0]      done,
    output logic [N_REQ-1:0]      err,
    output logic                  busy,
    input  logic                  dxl_dir,
    output logic [2:0]            rw_ad,
    output logic [31:0]           write_data,
    output logic                  write_en
);

    localparam int PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_MAX = max3(GAP_CYCLES, START_TO, TX_TO);
    localparam int CW      = $clog2(CNT_MAX + 1);

    sched_state_t      state, next_state;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     gnt_q;
    logic [PW-1:0]     win;
    logic              win_valid;
    logic              grant;
    logic              err_set;
    logic [31:0]       w1_q;

    logic [N_REQ-1:0]  ack_n, done_n, err_n;
    logic              busy_n, en_n;
    logic [2:0]        rw_n;
    logic [31:0]       data_n;

    // Never start a new frame while the UART still drives the half-duplex bus.
    assign grant = (state == IDLE) && win_valid && !dxl_dir;

    dxl_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .grant  (grant),
        .winner (win),
        .valid  (win_valid)
    );

    // Next-state logic; a timeout goes to GAP and flags the error for the done pulse.
    always_comb begin
        next_state = state;
        err_set    = 1'b0;
        case (state)
            IDLE:    if (grant) next_state = LD0;
            LD0:     next_state = LD1;
            LD1:     next_state = START;
            START:   next_state = CLEAR;
            CLEAR:   next_state = WAIT_HI;
            WAIT_HI: begin
                if (dxl_dir) begin
                    next_state = WAIT_LO;
                end else if (cnt == CW'(START_TO - 1)) begin
                    next_state = GAP;
                    err_set    = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!dxl_dir) begin
                    next_state = GAP;
                end else if (cnt == CW'(TX_TO - 1)) begin
                    next_state = GAP;
                    err_set    = 1'b1;
                end
            end
            GAP:     if (cnt == CW'(GAP_CYCLES - 1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the state being entered so every
    // output is registered yet aligned with its state; word 0 goes straight from the winner.
    always_comb begin
        rw_n   = RW_NONE;
        data_n = '0;
        en_n   = 1'b0;
        ack_n  = '0;
        done_n = '0;
        err_n  = '0;
        busy_n = (next_state != IDLE);
        case (next_state)
            LD0: begin
                rw_n   = RW_W0;
                data_n = cmd_w0[32*int'(win) +: 32];
                en_n   = 1'b1;
            end
            LD1: begin
                rw_n   = RW_W1;
                data_n = w1_q;
                en_n   = 1'b1;
            end
            START: begin
                rw_n   = RW_CTRL;
                data_n = 32'd1;
                en_n   = 1'b1;
            end
            CLEAR: begin
                rw_n   = RW_CTRL;
                data_n = 32'd0;
                en_n   = 1'b1;
            end
            default: ;
        endcase
        if (grant) begin
            ack_n[win] = 1'b1;
        end
        if (next_state == GAP && state != GAP) begin
            done_n[gnt_q] = 1'b1;
            err_n[gnt_q]  = err_set;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs, latched command and the shared saturating cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack        <= '0;
            done       <= '0;
            err        <= '0;
            busy       <= 1'b0;
            rw_ad      <= RW_NONE;
            write_data <= '0;
            write_en   <= 1'b0;
            cnt        <= '0;
            gnt_q      <= '0;
            w1_q       <= '0;
        end else begin
            ack        <= ack_n;
            done       <= done_n;
            err        <= err_n;
            busy       <= busy_n;
            rw_ad      <= rw_n;
            write_data <= data_n;
            write_en   <= en_n;
            if (next_state != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            if (grant) begin
                gnt_q <= win;
                w1_q  <= cmd_w1[32*int'(win) +: 32];
            end
        end
    end

endmodule

// File: tb/tb_dxl_cmd_scheduler.sv
// tb/tb_dxl_cmd_scheduler.sv - self-checking bench for dxl_cmd_scheduler
module tb_dxl_cmd_scheduler;

    localparam int N        = 2;
    localparam int GAP      = 8;
    localparam int START_TO = 40;
    localparam int TX_TO    = 300;
    localparam logic [N-1:0] ZN = '0;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [32*N-1:0]   cmd_w0, cmd_w1;
    logic [N-1:0]      ack, done, err;
    logic              busy;
    logic              dxl_dir;
    logic [2:0]        rw_ad;
    logic [31:0]       write_data;
    logic              write_en;

    int vectors = 0;
    int miscompares = 0;
    int last;
    logic [31:0] w0m [N];
    logic [31:0] w1m [N];

    dxl_cmd_scheduler #(
        .N_REQ(N), .GAP_CYCLES(GAP), .START_TO(START_TO), .TX_TO(TX_TO)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .cmd_w0(cmd_w0), .cmd_w1(cmd_w1),
        .ack(ack), .done(done), .err(err), .busy(busy), .dxl_dir(dxl_dir),
        .rw_ad(rw_ad), .write_data(write_data), .write_en(write_en)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int rr_pick(input logic [N-1:0] m);
        for (int off = 1; off <= N; off++) begin
            int idx;
            idx = (last + off) % N;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_src(input int s, input logic [31:0] a, input logic [31:0] b);
        w0m[s] = a;
        w1m[s] = b;
        cmd_w0[32*s +: 32] = a;
        cmd_w1[32*s +: 32] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req = '0; dxl_dir = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        last = N - 1;
    endtask

    // One full command: dir rises dly cycles after CLEAR (never if dly<0) and stays
    // high len cycles (forever if len<0). Returns at the first idle cycle after GAP.
    task automatic expect_cmd(input int src, input logic [31:0] w0, input logic [31:0] w1,
                              input int dly, input int len, input bit drop, input int exp_n);
        int n, dn;
        bit eerr, exp_busy;
        logic [N-1:0] oh, exp_done, exp_err;
        logic [2:0] exp_rw [3];
        logic [31:0] exp_d [3];
        oh = '0; oh[src] = 1'b1;
        exp_rw[0] = 3'b110; exp_rw[1] = 3'b100; exp_rw[2] = 3'b100;
        exp_d[0] = w1; exp_d[1] = 32'd1; exp_d[2] = 32'd0;
        n = 0;
        do begin @(negedge clk); n++; end while (ack == ZN && n < 400);
        vectors++;
        if ({ack, done, err, busy, rw_ad, write_en, write_data} !== {oh, ZN, ZN, 1'b1, 3'b101, 1'b1, w0}) begin
            miscompares++;
            $display("FAIL ld0 src=%0d: got ack=%b done=%b busy=%b rw_ad=%b en=%b data=%h, want ack=%b rw_ad=101 en=1 data=%h",
                     src, ack, done, busy, rw_ad, write_en, write_data, oh, w0);
        end
        if (exp_n > 0) begin
            vectors++;
            if (n != exp_n) begin
                miscompares++;
                $display("FAIL ack_latency src=%0d: got %0d cycles, want %0d", src, n, exp_n);
            end
        end
        if (drop) req[src] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({ack, done, err, busy, rw_ad, write_data} !== {ZN, ZN, ZN, 1'b1, exp_rw[i], exp_d[i]}) begin
                miscompares++;
                $display("FAIL load_step%0d src=%0d: got ack=%b done=%b busy=%b rw_ad=%b data=%h, want rw_ad=%b data=%h",
                         i + 1, src, ack, done, busy, rw_ad, write_data, exp_rw[i], exp_d[i]);
            end
        end
        if (dly < 0) begin
            dn = START_TO + 1; eerr = 1'b1;
        end else if (len < 0 || len > TX_TO) begin
            dn = dly + TX_TO + 1; eerr = 1'b1;
        end else begin
            dn = dly + len + 1; eerr = 1'b0;
        end
        for (int t = 1; t <= dn + GAP; t++) begin
            @(negedge clk);
            exp_done = (t == dn) ? oh : ZN;
            exp_err  = (t == dn && eerr) ? oh : ZN;
            exp_busy = (t < dn + GAP);
            vectors++;
            if ({ack, done, err, busy, rw_ad, write_en, write_data} !== {ZN, exp_done, exp_err, exp_busy, 3'b000, 1'b0, 32'h0}) begin
                miscompares++;
                $display("FAIL wait_gap src=%0d t=%0d: got ack=%b done=%b err=%b busy=%b rw_ad=%b en=%b data=%h, want done=%b err=%b busy=%b",
                         src, t, ack, done, err, busy, rw_ad, write_en, write_data, exp_done, exp_err, exp_busy);
            end
            if (dly >= 0 && t == dly) dxl_dir = 1'b1;
            if (dly >= 0 && len >= 0 && t == dly + len) dxl_dir = 1'b0;
        end
        last = src;
    endtask

    task automatic test_reset();
        reset = 1'b1; dxl_dir = 1'b0; req = N'($urandom);
        for (int s = 0; s < N; s++) set_src(s, $urandom, $urandom);
        repeat (3) @(negedge clk);
        vectors++;
        if ({ack, done, err, busy, rw_ad, write_en, write_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_hold: got ack=%b done=%b err=%b busy=%b rw_ad=%b en=%b data=%h, want all 0",
                     ack, done, err, busy, rw_ad, write_en, write_data);
        end
        req = '0; reset = 1'b0; last = N - 1;
        @(negedge clk);
        vectors++;
        if ({ack, done, err, busy, rw_ad, write_en, write_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_release: got ack=%b busy=%b rw_ad=%b, want all 0", ack, busy, rw_ad);
        end
    endtask

    task automatic test_single();
        set_src(0, 32'hE003_04FE, 32'h0000_0119);
        req[0] = 1'b1;
        expect_cmd(0, 32'hE003_04FE, 32'h0000_0119, 5, 200, 1'b1, 1);
    endtask

    task automatic test_round_robin();
        int src;
        do_reset();
        for (int s = 0; s < N; s++) set_src(s, $urandom, $urandom);
        req = '1;
        for (int c = 0; c < 3; c++) begin
            src = rr_pick(req);
            expect_cmd(src, w0m[src], w1m[src], $urandom_range(1, 20), $urandom_range(1, 50), 1'b0, (c == 0) ? 1 : 0);
        end
        req = '0;
    endtask

    task automatic test_start_timeout();
        int src;
        set_src(0, $urandom, $urandom);
        req[0] = 1'b1;
        src = rr_pick(req);
        expect_cmd(src, w0m[src], w1m[src], -1, 0, 1'b1, 0);
        set_src(1, $urandom, $urandom);
        req[1] = 1'b1;
        src = rr_pick(req);
        expect_cmd(src, w0m[src], w1m[src], 3, 10, 1'b1, 1);
    endtask

    task automatic test_tx_timeout();
        int src;
        set_src(0, $urandom, $urandom);
        req[0] = 1'b1;
        src = rr_pick(req);
        expect_cmd(src, w0m[src], w1m[src], 2, -1, 1'b1, 0);
        set_src(1, $urandom, $urandom);
        req[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({ack, busy} !== {ZN, 1'b0}) begin
                miscompares++;
                $display("FAIL dir_stuck_nogrant: got ack=%b busy=%b, want ack=0 busy=0", ack, busy);
            end
        end
        dxl_dir = 1'b0;
        src = rr_pick(req);
        expect_cmd(src, w0m[src], w1m[src], 4, 15, 1'b1, 1);
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        set_src(0, $urandom, $urandom);
        req[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (ack == ZN && n < 20);
        vectors++;
        if (ack !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_mid_ack: got ack=%b, want 01", ack);
        end
        req[0] = 1'b0;
        set_src(1, $urandom, $urandom);
        req[1] = 1'b1;
        repeat (4) @(negedge clk);
        dxl_dir = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ack, done, err, busy, rw_ad, write_en, write_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got ack=%b done=%b busy=%b rw_ad=%b en=%b data=%h, want all 0",
                     ack, done, busy, rw_ad, write_en, write_data);
        end
        reset = 1'b0;
        last = N - 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            vectors++;
            if ({ack, done, err, busy} !== {ZN, ZN, ZN, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_mid_quiet: got ack=%b done=%b err=%b busy=%b, want all 0", ack, done, err, busy);
            end
        end
        dxl_dir = 1'b0;
        expect_cmd(rr_pick(req), w0m[1], w1m[1], 4, 20, 1'b1, 1);
    endtask

    task automatic test_pulse_ignored();
        req = '0;
        set_src(0, $urandom, $urandom);
        set_src(1, $urandom, $urandom);
        req[0] = 1'b1;
        fork
            expect_cmd(0, w0m[0], w1m[0], 5, 30, 1'b1, 0);
            begin
                repeat (12) @(negedge clk);
                req[1] = 1'b1;
                @(negedge clk);
                req[1] = 1'b0;
            end
        join
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if ({ack, busy, rw_ad, write_en} !== {ZN, 1'b0, 3'b000, 1'b0}) begin
                miscompares++;
                $display("FAIL pulse_ignored: got ack=%b busy=%b rw_ad=%b en=%b, want all 0", ack, busy, rw_ad, write_en);
            end
        end
    endtask

    task automatic test_random();
        int src;
        logic [N-1:0] m;
        for (int c = 0; c < 8; c++) begin
            if (req == ZN) begin
                m = N'($urandom_range(1, (1 << N) - 1));
                for (int s = 0; s < N; s++) if (m[s]) set_src(s, $urandom, $urandom);
                req = m;
            end
            src = rr_pick(req);
            expect_cmd(src, w0m[src], w1m[src], $urandom_range(1, START_TO),
                       $urandom_range(1, 80), 1'b1, 0);
        end
        req = '0;
    endtask

    initial begin
        reset = 1'b1; req = '0; dxl_dir = 1'b0; cmd_w0 = '0; cmd_w1 = '0; last = N - 1;
        test_reset();
        test_single();
        test_round_robin();
        test_start_timeout();
        test_tx_timeout();
        test_reset_mid();
        test_pulse_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
